// File: rtl/cpu_interlock_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_interlock_pkg
// Brief   : Shared encodings for the moxie decode/execute interlock.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_interlock_pkg;

    localparam int NREGS = 16;
    localparam int REG_W = 4;
    localparam int CNT_W = 6;

    localparam logic [1:0] LONG_NONE = 2'b00;
    localparam logic [1:0] LONG_MUL  = 2'b01;
    localparam logic [1:0] LONG_DIV  = 2'b10;

    localparam logic [1:0] LFSM_IDLE = 2'd0;
    localparam logic [1:0] LFSM_BUSY = 2'd1;
    localparam logic [1:0] LFSM_DONE = 2'd2;

    // The reserved encoding 2'b11 behaves as a single-cycle op.
    function automatic logic is_long(input logic [1:0] kind);
        return (kind == LONG_MUL) || (kind == LONG_DIV);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_scoreboard.sv
//------------------------------------------------------------------------------
// Module  : cpu_scoreboard
// Brief   : Pending-write busy bits with one set port, one clear port and two
//           read ports. A set and clear of the same index leaves the bit set.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_scoreboard
    import cpu_interlock_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               set_en_i,
    input  logic [REG_W-1:0]   set_idx_i,
    input  logic               clr_en_i,
    input  logic [REG_W-1:0]   clr_idx_i,
    input  logic [REG_W-1:0]   rd_a_idx_i,
    input  logic [REG_W-1:0]   rd_b_idx_i,
    output logic               rd_a_o,
    output logic               rd_b_o,
    output logic [NREGS-1:0]   busy_o
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Clear first so a new writer issued in the retiring cycle keeps its bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_en_i) begin
            w_busy_nxt[clr_idx_i] = 1'b0;
        end
        if (set_en_i) begin
            w_busy_nxt[set_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign rd_a_o = r_busy[rd_a_idx_i];
    assign rd_b_o = r_busy[rd_b_idx_i];
    assign busy_o = r_busy;

endmodule

`default_nettype wire

// File: rtl/cpu_interlock.sv
//------------------------------------------------------------------------------
// Module  : cpu_interlock
// Brief   : Decode/execute interlock: scoreboard hazards, mul/div sequencing,
//           stall and post-branch squash. Option: CPU_INTERLOCK_FORWARD_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_interlock
    import cpu_interlock_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         dx_valid_i,
    input  logic [3:0]   dx_riA_i,
    input  logic [3:0]   dx_riB_i,
    input  logic         dx_rdA_i,
    input  logic         dx_rdB_i,
    input  logic         dx_wr_i,
    input  logic [1:0]   dx_long_i,
    input  logic         wb_valid_i,
    input  logic [3:0]   wb_index_i,
    input  logic         flush_i,
    output logic         stall_o,
    output logic         issue_o,
    output logic         flush_o,
    output logic         long_busy_o,
    output logic         long_done_o,
    output logic [15:0]  sb_o
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_flush;

    logic w_sb_a;
    logic w_sb_b;
    logic w_fwd_a;
    logic w_fwd_b;
    logic w_long;
    logic w_hazard;
    logic w_stall;
    logic w_issue;

    cpu_scoreboard u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_en_i   (w_issue & dx_wr_i),
        .set_idx_i  (dx_riA_i),
        .clr_en_i   (wb_valid_i),
        .clr_idx_i  (wb_index_i),
        .rd_a_idx_i (dx_riA_i),
        .rd_b_idx_i (dx_riB_i),
        .rd_a_o     (w_sb_a),
        .rd_b_o     (w_sb_b),
        .busy_o     (sb_o)
    );

`ifdef CPU_INTERLOCK_FORWARD_EN
    // A register retiring this cycle can be bypassed to a reader, not a writer.
    assign w_fwd_a = wb_valid_i && (wb_index_i == dx_riA_i);
    assign w_fwd_b = wb_valid_i && (wb_index_i == dx_riB_i);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    assign w_long   = is_long(dx_long_i);
    assign w_hazard = dx_valid_i & ((dx_rdA_i & w_sb_a & ~w_fwd_a) |
                                    (dx_rdB_i & w_sb_b & ~w_fwd_b) |
                                    (dx_wr_i  & w_sb_a));
    assign w_stall  = ~rst_i & dx_valid_i & ~flush_i &
                      (w_hazard | (w_long & (r_state != LFSM_IDLE)));
    assign w_issue  = ~rst_i & dx_valid_i & ~w_stall & ~flush_i;

    assign stall_o  = w_stall;
    assign issue_o  = w_issue;
    assign flush_o  = r_flush;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= LFSM_IDLE;
            r_count <= '0;
            r_flush <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_flush <= flush_i;
        end
    end

    // BUSY lasts LAT-1 cycles and DONE one more, so done lands LAT after issue.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            LFSM_IDLE: begin
                if (w_issue && w_long) begin
                    w_state_nxt = LFSM_BUSY;
                    w_count_nxt = (dx_long_i == LONG_MUL) ? MUL_LOAD : DIV_LOAD;
                end
            end
            LFSM_BUSY: begin
                if (r_count == '0) begin
                    w_state_nxt = LFSM_DONE;
                end else begin
                    w_count_nxt = r_count - 1'b1;
                end
            end
            LFSM_DONE: begin
                w_state_nxt = LFSM_IDLE;
            end
            default: begin
                w_state_nxt = LFSM_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        long_busy_o = (r_state != LFSM_IDLE);
        long_done_o = (r_state == LFSM_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_interlock.sv
//------------------------------------------------------------------------------
// Module  : tb_cpu_interlock
// Brief   : Directed self-checking bench for cpu_interlock (DIV_LAT=8).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_interlock;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;

    localparam int S_STALL = 0;
    localparam int S_ISSUE = 1;
    localparam int S_FLUSH = 2;
    localparam int S_BUSY  = 3;
    localparam int S_DONE  = 4;
    localparam int S_SB    = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dx_valid_i;
    logic [3:0]  dx_riA_i;
    logic [3:0]  dx_riB_i;
    logic        dx_rdA_i;
    logic        dx_rdB_i;
    logic        dx_wr_i;
    logic [1:0]  dx_long_i;
    logic        wb_valid_i;
    logic [3:0]  wb_index_i;
    logic        flush_i;
    logic        stall_o;
    logic        issue_o;
    logic        flush_o;
    logic        long_busy_o;
    logic        long_done_o;
    logic [15:0] sb_o;

    typedef struct {
        string       tag;
        int          sig;
        logic [15:0] val;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    cpu_interlock #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dx_valid_i  (dx_valid_i),
        .dx_riA_i    (dx_riA_i),
        .dx_riB_i    (dx_riB_i),
        .dx_rdA_i    (dx_rdA_i),
        .dx_rdB_i    (dx_rdB_i),
        .dx_wr_i     (dx_wr_i),
        .dx_long_i   (dx_long_i),
        .wb_valid_i  (wb_valid_i),
        .wb_index_i  (wb_index_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .issue_o     (issue_o),
        .flush_o     (flush_o),
        .long_busy_o (long_busy_o),
        .long_done_o (long_done_o),
        .sb_o        (sb_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] observe(input int sig);
        case (sig)
            S_STALL: return {15'd0, stall_o};
            S_ISSUE: return {15'd0, issue_o};
            S_FLUSH: return {15'd0, flush_o};
            S_BUSY:  return {15'd0, long_busy_o};
            S_DONE:  return {15'd0, long_done_o};
            default: return sb_o;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic ra, input logic rb, input logic w,
                         input logic [1:0] lg, input logic wbv, input logic [3:0] wbi,
                         input logic fl);
        dx_valid_i = v;   dx_riA_i = a;    dx_riB_i = b;
        dx_rdA_i   = ra;  dx_rdB_i = rb;   dx_wr_i  = w;
        dx_long_i  = lg;  wb_valid_i = wbv; wb_index_i = wbi;
        flush_i    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic expect_sig(input string tag, input int sig, input logic [15:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        q.push_back(e);
    endtask

    // Compare everything queued for this cycle mid-cycle, then advance.
    task automatic tick();
        exp_t        e;
        logic [15:0] obs;
        @(negedge clk_i);
        while (q.size() > 0) begin
            e   = q.pop_front();
            obs = observe(e.sig);
            checks++;
            assert (obs === e.val) passed++;
            else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        idle();
        @(posedge clk_i);
        #1;
        drive(1'b1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 4'd0, 1'b0);
        expect_sig("rst_stall", S_STALL, 16'd0);
        expect_sig("rst_issue", S_ISSUE, 16'd0);
        tick();
        rst_i = 1'b0;
        idle();
        expect_sig("rst_sb",    S_SB,    16'd0);
        expect_sig("rst_busy",  S_BUSY,  16'd0);
        expect_sig("rst_flush", S_FLUSH, 16'd0);
        expect_sig("rst_done",  S_DONE,  16'd0);
        tick();

        // RAW: ldi $r1 then a reader of r1, retired in the third cycle
        drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        expect_sig("raw_ldi_issue", S_ISSUE, 16'd1);
        expect_sig("raw_ldi_stall", S_STALL, 16'd0);
        tick();
        drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 4'd0, 1'b0);
        expect_sig("raw_t1_stall", S_STALL, 16'd1);
        expect_sig("raw_t1_issue", S_ISSUE, 16'd0);
        expect_sig("raw_t1_sb",    S_SB,    16'h0002);
        tick();
        expect_sig("raw_t2_stall", S_STALL, 16'd1);
        expect_sig("raw_t2_sb",    S_SB,    16'h0002);
        tick();
        wb_valid_i = 1'b1;
        wb_index_i = 4'd1;
        expect_sig("raw_t3_sb", S_SB, 16'h0002);
`ifdef CPU_INTERLOCK_FORWARD_EN
        expect_sig("raw_t3_stall", S_STALL, 16'd0);
        expect_sig("raw_t3_issue", S_ISSUE, 16'd1);
        tick();
        idle();
        expect_sig("raw_t4_sb", S_SB, 16'h0000);
        tick();
`else
        expect_sig("raw_t3_stall", S_STALL, 16'd1);
        expect_sig("raw_t3_issue", S_ISSUE, 16'd0);
        tick();
        wb_valid_i = 1'b0;
        expect_sig("raw_t4_stall", S_STALL, 16'd0);
        expect_sig("raw_t4_issue", S_ISSUE, 16'd1);
        expect_sig("raw_t4_sb",    S_SB,    16'h0000);
        tick();
`endif

        // mul.l r6, independent add.l r7, then div.l r9 held until IDLE
        drive(1'b1, 4'd6, 4'd4, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 4'd0, 1'b0);
        expect_sig("mul_issue", S_ISSUE, 16'd1);
        expect_sig("mul_busy0", S_BUSY,  16'd0);
        tick();
        drive(1'b1, 4'd7, 4'd8, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        expect_sig("add_issue", S_ISSUE, 16'd1);
        expect_sig("mul_busy1", S_BUSY,  16'd1);
        expect_sig("mul_sb1",   S_SB,    16'h0040);
        tick();
        drive(1'b1, 4'd9, 4'd10, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 4'd0, 1'b0);
        expect_sig("div_t2_stall", S_STALL, 16'd1);
        expect_sig("mul_busy2",    S_BUSY,  16'd1);
        expect_sig("mul_done2",    S_DONE,  16'd0);
        expect_sig("mul_sb2",      S_SB,    16'h00C0);
        tick();
        expect_sig("div_t3_stall", S_STALL, 16'd1);
        expect_sig("mul_busy3",    S_BUSY,  16'd1);
        expect_sig("mul_done3",    S_DONE,  16'd1);
        tick();
        expect_sig("div_t4_issue", S_ISSUE, 16'd1);
        expect_sig("mul_busy4",    S_BUSY,  16'd0);
        expect_sig("mul_done4",    S_DONE,  16'd0);
        tick();
        for (int i = 1; i <= DIV_LAT + 1; i++) begin
            idle();
            if (i == 2) begin
                drive(1'b1, 4'd10, 4'd0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 4'd0, 1'b0);
                expect_sig("rsvd_long_issue", S_ISSUE, 16'd1);
            end
            if (i == 1) expect_sig("div_sb", S_SB, 16'h02C0);
            expect_sig($sformatf("div_busy_%0d", i), S_BUSY, (i <= DIV_LAT) ? 16'd1 : 16'd0);
            expect_sig($sformatf("div_done_%0d", i), S_DONE, (i == DIV_LAT) ? 16'd1 : 16'd0);
            tick();
        end

        // flush with a retirement in the same cycle
        drive(1'b1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'd6, 1'b1);
        expect_sig("flush_issue", S_ISSUE, 16'd0);
        expect_sig("flush_stall", S_STALL, 16'd0);
        expect_sig("flush_o_pre", S_FLUSH, 16'd0);
        tick();
        idle();
        expect_sig("flush_o_pulse", S_FLUSH, 16'd1);
        expect_sig("flush_sb",      S_SB,    16'h0280);
        tick();
        expect_sig("flush_o_post", S_FLUSH, 16'd0);
        tick();

        // issue a writer of r5 while r5 retires: set wins
        drive(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 4'd5, 1'b0);
        expect_sig("setclr_issue", S_ISSUE, 16'd1);
        tick();
        idle();
        expect_sig("setclr_sb", S_SB, 16'h02A0);
        tick();

        // WAW on r3: retires in the third cycle, writer issues after
        drive(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        expect_sig("waw_first_issue", S_ISSUE, 16'd1);
        tick();
        expect_sig("waw_t1_stall", S_STALL, 16'd1);
        expect_sig("waw_t1_sb",    S_SB,    16'h02A8);
        tick();
        wb_valid_i = 1'b1;
        wb_index_i = 4'd3;
        expect_sig("waw_t2_stall", S_STALL, 16'd1);
        tick();
        wb_valid_i = 1'b0;
        expect_sig("waw_t3_issue", S_ISSUE, 16'd1);
        expect_sig("waw_t3_sb",    S_SB,    16'h02A0);
        tick();
        idle();
        expect_sig("waw_t4_sb", S_SB, 16'h02A8);
        tick();

        // reset in BUSY with sb=0x0022
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b1, 4'd5, 4'd0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 4'd0, 1'b0);
        expect_sig("rb_mul_issue", S_ISSUE, 16'd1);
        tick();
        idle();
        expect_sig("rb_sb_pre",   S_SB,   16'h0022);
        expect_sig("rb_busy_pre", S_BUSY, 16'd1);
        tick();
        rst_i = 1'b1;
        drive(1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 4'd0, 1'b1);
        expect_sig("rb_rst_issue", S_ISSUE, 16'd0);
        expect_sig("rb_rst_stall", S_STALL, 16'd0);
        tick();
        rst_i = 1'b0;
        idle();
        expect_sig("rb_sb",    S_SB,    16'h0000);
        expect_sig("rb_busy",  S_BUSY,  16'd0);
        expect_sig("rb_flush", S_FLUSH, 16'd0);
        for (int i = 0; i < 4; i++) begin
            expect_sig($sformatf("rb_done_%0d", i), S_DONE, 16'd0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
